// File: rtl/fft_twiddle_feed_16.sv
// Feeder for the 16-lane complex multiplier array: it accepts sample beats,
// fetches the matching twiddle row, aligns the two, and tags products.
module fft_twiddle_feed_16 #(
    parameter int unsigned MULT_LATENCY = 7,
    parameter int unsigned FRAME_BEATS  = 16,
    parameter int unsigned MAX_STAGES   = 8,
    parameter int unsigned TW_ADDR_W    = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           cfg_stages,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_re [15:0],
    input  logic [31:0]          in_im [15:0],
    output logic                 tw_rd_en,
    output logic [TW_ADDR_W-1:0] tw_addr,
    input  logic [31:0]          tw_re [15:0],
    input  logic [31:0]          tw_im [15:0],
    output logic [31:0]          a [15:0],
    output logic [31:0]          b [15:0],
    output logic [31:0]          c [15:0],
    output logic [31:0]          d [15:0],
    output logic                 mult_in_valid,
    output logic                 prod_valid,
    output logic                 prod_sof,
    output logic                 prod_eof,
    output logic [2:0]           prod_stage
);

    localparam int unsigned LANES  = 16;
    localparam int unsigned BEAT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int unsigned LAST   = MULT_LATENCY - 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    typedef struct packed {
        logic       sof;
        logic       eof;
        logic [2:0] stage;
        logic       last;
    } tag_t;

    state_t              state_q, state_d;
    logic [3:0]          stages_q, stages_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [2:0]          stage_q, stage_d;

    logic                tw_rd_en_q, tw_rd_en_d;
    logic [TW_ADDR_W-1:0] tw_addr_q, tw_addr_d;
    logic [31:0]         s1_re_q [15:0];
    logic [31:0]         s1_re_d [15:0];
    logic [31:0]         s1_im_q [15:0];
    logic [31:0]         s1_im_d [15:0];
    tag_t                s1_tag_q, s1_tag_d;

    logic                s2_valid_q, s2_valid_d;
    logic [31:0]         s2_re_q [15:0];
    logic [31:0]         s2_re_d [15:0];
    logic [31:0]         s2_im_q [15:0];
    logic [31:0]         s2_im_d [15:0];
    tag_t                s2_tag_q, s2_tag_d;

    logic [31:0]         a_q [15:0];
    logic [31:0]         a_d [15:0];
    logic [31:0]         b_q [15:0];
    logic [31:0]         b_d [15:0];
    logic [31:0]         c_q [15:0];
    logic [31:0]         c_d [15:0];
    logic [31:0]         d_q [15:0];
    logic [31:0]         d_d [15:0];
    logic                mult_valid_q, mult_valid_d;
    tag_t                mult_tag_q, mult_tag_d;

    logic [MULT_LATENCY-1:0] dl_valid_q, dl_valid_d;
    tag_t                dl_tag_q [MULT_LATENCY];
    tag_t                dl_tag_d [MULT_LATENCY];

    logic                accept;
    logic                beat_wrap;
    logic                last_beat;
    logic [3:0]          stages_clamped;

    assign accept    = in_valid && in_ready;
    assign beat_wrap = (beat_q == BEAT_W'(FRAME_BEATS - 1));
    assign last_beat = beat_wrap && ({1'b0, stage_q} == (stages_q - 4'd1));

    always_comb begin
        stages_clamped = cfg_stages;
        if (cfg_stages == 4'd0) begin
            stages_clamped = 4'd1;
        end else if (cfg_stages > 4'(MAX_STAGES)) begin
            stages_clamped = 4'(MAX_STAGES);
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = STREAM;
            STREAM:  if (accept && last_beat) state_d = DRAIN;
            DRAIN:   if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs; the run ends on the final beat's product, not on a count
    always_comb begin
        in_ready = (state_q == STREAM);
        busy     = (state_q != IDLE);
        done     = (state_q == DRAIN) && dl_valid_q[LAST] && dl_tag_q[LAST].last;
    end

    always_comb begin
        stages_d = stages_q;
        beat_d   = beat_q;
        stage_d  = stage_q;
        if ((state_q == IDLE) && start) begin
            stages_d = stages_clamped;
            beat_d   = '0;
            stage_d  = '0;
        end else if (accept) begin
            if (beat_wrap) begin
                beat_d  = '0;
                stage_d = stage_q + 3'd1;
            end else begin
                beat_d  = beat_q + BEAT_W'(1);
            end
        end
    end

    // Samples wait two cycles (s1, s2) so they meet the ROM data at the operand registers.
    always_comb begin
        tw_rd_en_d = accept;
        tw_addr_d  = tw_addr_q;
        s1_tag_d   = s1_tag_q;
        s1_re_d    = s1_re_q;
        s1_im_d    = s1_im_q;
        if (accept) begin
            tw_addr_d = TW_ADDR_W'(stage_q) * TW_ADDR_W'(FRAME_BEATS) + TW_ADDR_W'(beat_q);
            s1_tag_d  = '{sof: (beat_q == '0), eof: beat_wrap, stage: stage_q, last: last_beat};
            s1_re_d   = in_re;
            s1_im_d   = in_im;
        end

        s2_valid_d = tw_rd_en_q;
        s2_tag_d   = s2_tag_q;
        s2_re_d    = s2_re_q;
        s2_im_d    = s2_im_q;
        if (tw_rd_en_q) begin
            s2_tag_d = s1_tag_q;
            s2_re_d  = s1_re_q;
            s2_im_d  = s1_im_q;
        end

        mult_valid_d = s2_valid_q;
        mult_tag_d   = mult_tag_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        d_d          = d_q;
        if (s2_valid_q) begin
            mult_tag_d = s2_tag_q;
            a_d        = s2_re_q;
            b_d        = s2_im_q;
            c_d        = tw_re;
            d_d        = tw_im;
        end
    end

    always_comb begin
        dl_valid_d    = dl_valid_q;
        dl_tag_d      = dl_tag_q;
        dl_valid_d[0] = mult_valid_q;
        dl_tag_d[0]   = mult_tag_q;
        for (int unsigned i = 1; i < MULT_LATENCY; i++) begin
            dl_valid_d[i] = dl_valid_q[i-1];
            dl_tag_d[i]   = dl_tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stages_q     <= 4'd1;
            beat_q       <= '0;
            stage_q      <= '0;
            tw_rd_en_q   <= 1'b0;
            tw_addr_q    <= '0;
            s1_tag_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_tag_q     <= '0;
            mult_valid_q <= 1'b0;
            mult_tag_q   <= '0;
            dl_valid_q   <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                s1_re_q[i] <= '0;
                s1_im_q[i] <= '0;
                s2_re_q[i] <= '0;
                s2_im_q[i] <= '0;
                a_q[i]     <= '0;
                b_q[i]     <= '0;
                c_q[i]     <= '0;
                d_q[i]     <= '0;
            end
            for (int unsigned i = 0; i < MULT_LATENCY; i++) begin
                dl_tag_q[i] <= '0;
            end
        end else begin
            stages_q     <= stages_d;
            beat_q       <= beat_d;
            stage_q      <= stage_d;
            tw_rd_en_q   <= tw_rd_en_d;
            tw_addr_q    <= tw_addr_d;
            s1_tag_q     <= s1_tag_d;
            s1_re_q      <= s1_re_d;
            s1_im_q      <= s1_im_d;
            s2_valid_q   <= s2_valid_d;
            s2_tag_q     <= s2_tag_d;
            s2_re_q      <= s2_re_d;
            s2_im_q      <= s2_im_d;
            mult_valid_q <= mult_valid_d;
            mult_tag_q   <= mult_tag_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            d_q          <= d_d;
            dl_valid_q   <= dl_valid_d;
            dl_tag_q     <= dl_tag_d;
        end
    end

    assign tw_rd_en      = tw_rd_en_q;
    assign tw_addr       = tw_addr_q;
    assign a             = a_q;
    assign b             = b_q;
    assign c             = c_q;
    assign d             = d_q;
    assign mult_in_valid = mult_valid_q;
    assign prod_valid    = dl_valid_q[LAST];
    assign prod_sof      = dl_valid_q[LAST] && dl_tag_q[LAST].sof;
    assign prod_eof      = dl_valid_q[LAST] && dl_tag_q[LAST].eof;
    assign prod_stage    = dl_tag_q[LAST].stage;

endmodule

// File: tb/tb_fft_twiddle_feed_16.sv
// Directed bench for fft_twiddle_feed_16: a negedge monitor logs handshake,
// ROM reads, operands and products; each test task checks its own log.
module tb_fft_twiddle_feed_16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  cfg_stages = 4'd0;
    logic        busy, done, in_valid = 1'b0, in_ready;
    logic [31:0] in_re [15:0];
    logic [31:0] in_im [15:0];
    logic        tw_rd_en;
    logic [6:0]  tw_addr;
    logic [31:0] tw_re [15:0];
    logic [31:0] tw_im [15:0];
    logic [31:0] a [15:0];
    logic [31:0] b [15:0];
    logic [31:0] c [15:0];
    logic [31:0] d [15:0];
    logic        mult_in_valid, prod_valid, prod_sof, prod_eof;
    logic [2:0]  prod_stage;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    fft_twiddle_feed_16 #(.MULT_LATENCY(7), .FRAME_BEATS(16), .MAX_STAGES(8), .TW_ADDR_W(7)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_stages(cfg_stages),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .tw_rd_en(tw_rd_en), .tw_addr(tw_addr),
        .tw_re(tw_re), .tw_im(tw_im), .a(a), .b(b), .c(c), .d(d),
        .mult_in_valid(mult_in_valid), .prod_valid(prod_valid),
        .prod_sof(prod_sof), .prod_eof(prod_eof), .prod_stage(prod_stage)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: row 5 is unity, other rows carry their address and lane.
    always @(posedge clk) begin
        if (tw_rd_en) begin
            for (int k = 0; k < 16; k++) begin
                if (tw_addr == 7'd5) begin
                    tw_re[k] <= 32'h3F80_0000;
                    tw_im[k] <= 32'h0000_0000;
                end else begin
                    tw_re[k] <= 32'hC000_0000 | (32'(tw_addr) << 8) | 32'(k);
                    tw_im[k] <= 32'h5000_0000 | (32'(tw_addr) << 8) | 32'(k);
                end
            end
        end
    end

    function automatic logic [31:0] lane_float(input int k);
        case (k)
            0: return 32'h0000_0000;  1: return 32'h3F80_0000;
            2: return 32'h4000_0000;  3: return 32'h4040_0000;
            4: return 32'h4080_0000;  5: return 32'h40A0_0000;
            6: return 32'h40C0_0000;  7: return 32'h40E0_0000;
            8: return 32'h4100_0000;  9: return 32'h4110_0000;
            10: return 32'h4120_0000; 11: return 32'h4130_0000;
            12: return 32'h4140_0000; 13: return 32'h4150_0000;
            14: return 32'h4160_0000; 15: return 32'h4170_0000;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Monitor log
    logic log_clr = 1'b0;
    int n_acc, n_rd, n_mult, n_prod, n_done, done_edge;
    int acc_edge [256];
    int rd_edge [256];
    int rd_addr [256];
    int mult_edge [256];
    int prod_edge [256];
    logic prod_sof_l [256];
    logic prod_eof_l [256];
    logic [2:0] prod_stage_l [256];
    logic [31:0] snap_a [16];
    logic [31:0] snap_b [16];
    logic [31:0] snap_c [16];
    logic [31:0] snap_d [16];

    always @(negedge clk) begin
        if (log_clr) begin
            n_acc = 0; n_rd = 0; n_mult = 0; n_prod = 0; n_done = 0; done_edge = -1;
        end else begin
            if (in_valid && in_ready && n_acc < 256) begin acc_edge[n_acc] = cyc + 1; n_acc++; end
            if (tw_rd_en && n_rd < 256) begin rd_edge[n_rd] = cyc; rd_addr[n_rd] = int'(tw_addr); n_rd++; end
            if (mult_in_valid && n_mult < 256) begin
                mult_edge[n_mult] = cyc;
                if (n_mult == 5) begin
                    for (int k = 0; k < 16; k++) begin
                        snap_a[k] = a[k]; snap_b[k] = b[k]; snap_c[k] = c[k]; snap_d[k] = d[k];
                    end
                end
                n_mult++;
            end
            if (prod_valid && n_prod < 256) begin
                prod_edge[n_prod] = cyc; prod_sof_l[n_prod] = prod_sof;
                prod_eof_l[n_prod] = prod_eof; prod_stage_l[n_prod] = prod_stage; n_prod++;
            end
            if (done) begin n_done++; done_edge = cyc; end
        end
    end

    function automatic logic [31:0] all_out_or();
        logic [31:0] r;
        r = {24'b0, busy, done, in_ready, tw_rd_en, mult_in_valid, prod_valid, prod_sof, prod_eof}
            | 32'(tw_addr) | 32'(prod_stage);
        for (int k = 0; k < 16; k++) r = r | a[k] | b[k] | c[k] | d[k];
        return r;
    endfunction

    task automatic clear_log();
        @(posedge clk); #1; log_clr = 1'b1;
        @(negedge clk); #1; log_clr = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] cfg);
        @(posedge clk); #1; cfg_stages = cfg; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    // Offers beats until the DUT leaves STREAM or the cycle limit expires;
    // ign_at >= 0 pulses start (cfg 5) on that iteration.
    task automatic drive(input bit gapped, input int limit, input int ign_at);
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            start = (i == ign_at);
            if (i == ign_at) cfg_stages = 4'd5;
            if (!in_ready) begin in_valid = 1'b0; break; end
            in_valid = gapped ? (i % 2 == 0) : 1'b1;
        end
        @(posedge clk); #1; in_valid = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0;
        total++; if (all_out_or() !== 32'h0) begin bad++; $display("FAIL reset_outputs got=%0h want=0", all_out_or()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    endtask

    task automatic test_single_stage();
        clear_log();
        do_start(4'd1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy got=%0b want=1", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL t1_in_ready got=%0b want=1", in_ready); end
        drive(1'b0, 40, -1);
        repeat (20) @(posedge clk);
        #1;
        total++; if (n_acc !== 16) begin bad++; $display("FAIL t1_accepts got=%0d want=16", n_acc); end
        total++; if (n_rd !== 16) begin bad++; $display("FAIL t1_reads got=%0d want=16", n_rd); end
        for (int i = 0; i < 16; i++) begin
            total++; if (rd_addr[i] !== i) begin bad++; $display("FAIL t1_addr[%0d] got=%0d want=%0d", i, rd_addr[i], i); end
            total++; if (rd_edge[i] !== acc_edge[0] + i) begin bad++; $display("FAIL t1_rd_edge[%0d] got=%0d want=%0d", i, rd_edge[i], acc_edge[0] + i); end
        end
        total++; if (mult_edge[0] !== acc_edge[0] + 2) begin bad++; $display("FAIL t1_mult_lat got=%0d want=%0d", mult_edge[0], acc_edge[0] + 2); end
        total++; if (n_prod !== 16) begin bad++; $display("FAIL t1_prods got=%0d want=16", n_prod); end
        total++; if (prod_edge[0] !== acc_edge[0] + 9) begin bad++; $display("FAIL t1_prod_lat got=%0d want=%0d", prod_edge[0], acc_edge[0] + 9); end
        total++; if (prod_edge[15] !== acc_edge[0] + 24) begin bad++; $display("FAIL t1_prod_last got=%0d want=%0d", prod_edge[15], acc_edge[0] + 24); end
        for (int i = 0; i < 16; i++) begin
            total++; if (prod_sof_l[i] !== (i == 0)) begin bad++; $display("FAIL t1_sof[%0d] got=%0b want=%0b", i, prod_sof_l[i], i == 0); end
            total++; if (prod_eof_l[i] !== (i == 15)) begin bad++; $display("FAIL t1_eof[%0d] got=%0b want=%0b", i, prod_eof_l[i], i == 15); end
        end
        total++; if (n_done !== 1) begin bad++; $display("FAIL t1_done_count got=%0d want=1", n_done); end
        total++; if (done_edge !== acc_edge[0] + 24) begin bad++; $display("FAIL t1_done_edge got=%0d want=%0d", done_edge, acc_edge[0] + 24); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy_end got=%0b want=0", busy); end
    endtask

    task automatic test_twiddle_align();
        for (int k = 0; k < 16; k++) begin
            total++; if (snap_c[k] !== 32'h3F80_0000) begin bad++; $display("FAIL row5_c[%0d] got=%0h want=3f800000", k, snap_c[k]); end
            total++; if (snap_d[k] !== 32'h0) begin bad++; $display("FAIL row5_d[%0d] got=%0h want=0", k, snap_d[k]); end
            total++; if (snap_a[k] !== lane_float(k)) begin bad++; $display("FAIL row5_a[%0d] got=%0h want=%0h", k, snap_a[k], lane_float(k)); end
            total++; if (snap_b[k] !== (lane_float(k) | 32'h8000_0000)) begin bad++; $display("FAIL row5_b[%0d] got=%0h want=%0h", k, snap_b[k], lane_float(k) | 32'h8000_0000); end
        end
    endtask

    task automatic test_gapped_three_stage();
        clear_log();
        do_start(4'd3);
        drive(1'b1, 200, -1);
        repeat (20) @(posedge clk);
        #1;
        total++; if (n_acc !== 48) begin bad++; $display("FAIL t2_accepts got=%0d want=48", n_acc); end
        total++; if (rd_addr[47] !== 47) begin bad++; $display("FAIL t2_last_addr got=%0d want=47", rd_addr[47]); end
        total++; if (n_prod !== 48) begin bad++; $display("FAIL t2_prods got=%0d want=48", n_prod); end
        for (int i = 0; i < 48; i++) begin
            total++; if (prod_edge[i] !== acc_edge[i] + 9) begin bad++; $display("FAIL t2_prod_edge[%0d] got=%0d want=%0d", i, prod_edge[i], acc_edge[i] + 9); end
        end
        total++; if (prod_edge[1] - prod_edge[0] !== 2) begin bad++; $display("FAIL t2_gap got=%0d want=2", prod_edge[1] - prod_edge[0]); end
        total++; if (prod_stage_l[15] !== 3'd0) begin bad++; $display("FAIL t2_stage15 got=%0d want=0", prod_stage_l[15]); end
        total++; if (prod_stage_l[16] !== 3'd1) begin bad++; $display("FAIL t2_stage16 got=%0d want=1", prod_stage_l[16]); end
        total++; if (prod_stage_l[32] !== 3'd2) begin bad++; $display("FAIL t2_stage32 got=%0d want=2", prod_stage_l[32]); end
        total++; if (prod_sof_l[32] !== 1'b1) begin bad++; $display("FAIL t2_sof32 got=%0b want=1", prod_sof_l[32]); end
        total++; if (prod_eof_l[31] !== 1'b1) begin bad++; $display("FAIL t2_eof31 got=%0b want=1", prod_eof_l[31]); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL t2_done_count got=%0d want=1", n_done); end
        total++; if (done_edge !== prod_edge[47]) begin bad++; $display("FAIL t2_done_edge got=%0d want=%0d", done_edge, prod_edge[47]); end
    endtask

    task automatic test_stage_clamp();
        clear_log();
        do_start(4'd0);
        drive(1'b0, 300, -1);
        repeat (20) @(posedge clk);
        #1;
        total++; if (n_acc !== 16) begin bad++; $display("FAIL cfg0_accepts got=%0d want=16", n_acc); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL cfg0_done got=%0d want=1", n_done); end
        clear_log();
        do_start(4'd12);
        drive(1'b0, 300, -1);
        repeat (20) @(posedge clk);
        #1;
        total++; if (n_acc !== 128) begin bad++; $display("FAIL cfg12_accepts got=%0d want=128", n_acc); end
        total++; if (rd_addr[127] !== 127) begin bad++; $display("FAIL cfg12_last_addr got=%0d want=127", rd_addr[127]); end
        total++; if (n_prod !== 128) begin bad++; $display("FAIL cfg12_prods got=%0d want=128", n_prod); end
        total++; if (prod_stage_l[127] !== 3'd7) begin bad++; $display("FAIL cfg12_stage got=%0d want=7", prod_stage_l[127]); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL cfg12_done got=%0d want=1", n_done); end
    endtask

    task automatic test_reset_mid_run();
        clear_log();
        do_start(4'd1);
        drive(1'b0, 5, -1);
        total++; if (n_acc !== 5) begin bad++; $display("FAIL rst_pre_accepts got=%0d want=5", n_acc); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (all_out_or() !== 32'h0) begin bad++; $display("FAIL rst_outputs got=%0h want=0", all_out_or()); end
        log_clr = 1'b1;
        @(negedge clk); #1; log_clr = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        total++; if (n_mult !== 0) begin bad++; $display("FAIL rst_flush_mult got=%0d want=0", n_mult); end
        total++; if (n_prod !== 0) begin bad++; $display("FAIL rst_flush_prod got=%0d want=0", n_prod); end
        total++; if (n_done !== 0) begin bad++; $display("FAIL rst_no_done got=%0d want=0", n_done); end
        clear_log();
        do_start(4'd1);
        drive(1'b0, 40, -1);
        repeat (20) @(posedge clk);
        #1;
        total++; if (n_acc !== 16) begin bad++; $display("FAIL rst_rerun_accepts got=%0d want=16", n_acc); end
        total++; if (n_prod !== 16) begin bad++; $display("FAIL rst_rerun_prods got=%0d want=16", n_prod); end
        total++; if (rd_addr[0] !== 0) begin bad++; $display("FAIL rst_rerun_addr0 got=%0d want=0", rd_addr[0]); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL rst_rerun_done got=%0d want=1", n_done); end
    endtask

    task automatic test_start_ignored();
        clear_log();
        do_start(4'd2);
        drive(1'b0, 100, 10);
        @(posedge clk); #1; cfg_stages = 4'd1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        total++; if (n_acc !== 32) begin bad++; $display("FAIL ign_accepts got=%0d want=32", n_acc); end
        for (int i = 0; i < 32; i++) begin
            total++; if (rd_addr[i] !== i) begin bad++; $display("FAIL ign_addr[%0d] got=%0d want=%0d", i, rd_addr[i], i); end
        end
        total++; if (n_prod !== 32) begin bad++; $display("FAIL ign_prods got=%0d want=32", n_prod); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL ign_done got=%0d want=1", n_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy got=%0b want=0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ign_in_ready got=%0b want=0", in_ready); end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            in_re[k] = lane_float(k);
            in_im[k] = lane_float(k) | 32'h8000_0000;
        end
        test_reset();
        test_single_stage();
        test_twiddle_align();
        test_gapped_three_stage();
        test_stage_clamp();
        test_reset_mid_run();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
